muldiv_sequencer: RTL

Multi-cycle execution unit for the RV64 M-extension ALU control codes 6'h1F–6'h2B. It sits beside the EX-stage ALU and accepts an op together with the already-forwarded operands. While busy it holds the pipeline with a stall. When done it returns one registered result with its destination register.
- Multiplies are fixed-latency.
- Divides and remainders are iterative, one quotient bit per cycle.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_sequencer_div.sv | 60 ++++++
 rtl/muldiv_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for the M-extension sequencer.
package muldiv_pkg;

    localparam logic [5:0] OP_MUL    = 6'h1F;
    localparam logic [5:0] OP_MULH   = 6'h20;
    localparam logic [5:0] OP_MULHSU = 6'h21;
    localparam logic [5:0] OP_MULHU  = 6'h22;
    localparam logic [5:0] OP_DIV    = 6'h23;
    localparam logic [5:0] OP_DIVU   = 6'h24;
    localparam logic [5:0] OP_REM    = 6'h25;
    localparam logic [5:0] OP_REMU   = 6'h26;
    localparam logic [5:0] OP_MULW   = 6'h27;
    localparam logic [5:0] OP_DIVW   = 6'h28;
    localparam logic [5:0] OP_DIVUW  = 6'h29;
    localparam logic [5:0] OP_REMW   = 6'h2A;
    localparam logic [5:0] OP_REMUW  = 6'h2B;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic is_muldiv_op(input logic [5:0] op);
        return (op >= OP_MUL) && (op <= OP_REMUW);
    endfunction

    function automatic logic is_word_op(input logic [5:0] op);
        return (op >= OP_MULW) && (op <= OP_REMUW);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    // Signed divide/remainder ops: both operands are two's complement.
    function automatic logic is_signed_op(input logic [5:0] op);
        return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_rem_op(input logic [5:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div.sv
// Unsigned restoring divider, one quotient bit per cycle for iterCount cycles after start.
// quotient/remainder show the values after the current iteration and are final while done is high.
module div_unit #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic [6:0]   iterCount,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam logic [6:0] WIDTH7 = 7'(W);

    logic [W-1:0] quoReg;
    logic [W-1:0] remReg;
    logic [W-1:0] divisorReg;
    logic [6:0]   cnt;
    logic         busy;
    logic [W:0]   partial;
    logic [W:0]   diff;

    // quoReg starts as the dividend left-aligned and fills with quotient bits from the bottom.
    assign partial   = {remReg, quoReg[W-1]};
    assign diff      = partial - {1'b0, divisorReg};
    assign quotient  = {quoReg[W-2:0], ~diff[W]};
    assign remainder = diff[W] ? partial[W-1:0] : diff[W-1:0];
    assign done      = busy && (cnt == 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quoReg     <= '0;
            remReg     <= '0;
            divisorReg <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            quoReg     <= dividend << (WIDTH7 - iterCount);
            remReg     <= '0;
            divisorReg <= divisor;
            cnt        <= iterCount;
            busy       <= 1'b1;
        end else if (busy) begin
            quoReg <= quotient;
            remReg <= remainder;
            cnt    <= cnt - 7'd1;
            if (cnt == 7'd1) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV64 M-extension multi-cycle unit: mul in MUL_LATENCY+1 cycles, div/rem in 65 (33 for W ops), stall held while busy.
// MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MUL_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [5:0]                in_op,
    input  logic [BUS_DATA_WIDTH-1:0] in_a,
    input  logic [BUS_DATA_WIDTH-1:0] in_b,
    input  logic [4:0]                in_dest_reg,
    input  logic                      flush,
    output logic                      in_ready,
    output logic                      stall,
    output logic                      out_valid,
    output logic [BUS_DATA_WIDTH-1:0] out_result,
    output logic [4:0]                out_dest_reg
);

    localparam int XW = BUS_DATA_WIDTH;
    localparam int HW = WORD_WIDTH;
    localparam int CW = $clog2(MUL_LATENCY + 1);
    localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_LATENCY - 1);
    localparam logic [6:0]    ITER_FULL = 7'(XW);
    localparam logic [6:0]    ITER_WORD = 7'(HW);

    state_t          state;
    logic [XW-1:0]   aReg;
    logic [XW-1:0]   bReg;
    logic [5:0]      opReg;
    logic [4:0]      destReg;
    logic [CW-1:0]   mulCnt;
    logic            acceptOp;
    logic            earlyOut;
    logic [XW-1:0]   divQuo;
    logic [XW-1:0]   divRem;
    logic            divDone;
    logic [2*XW-1:0] mulA;
    logic [2*XW-1:0] mulB;
    logic [2*XW-1:0] product;
    logic [XW-1:0]   mulResult;

    function automatic logic [XW-1:0] magnitude(input logic [5:0] op, input logic [XW-1:0] x);
        logic [XW-1:0] res;
        if (is_word_op(op)) begin
            res = {{(XW-HW){1'b0}}, x[HW-1:0]};
            if (is_signed_op(op) && x[HW-1]) res = {{(XW-HW){1'b0}}, -x[HW-1:0]};
        end else begin
            res = x;
            if (is_signed_op(op) && x[XW-1]) res = -x;
        end
        return res;
    endfunction

    function automatic logic divZero(input logic [5:0] op, input logic [XW-1:0] b);
        return is_word_op(op) ? (b[HW-1:0] == '0) : (b == '0);
    endfunction

    function automatic logic divOvf(input logic [5:0] op, input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic ovf;
        if (is_word_op(op)) ovf = (a[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) && (&b[HW-1:0]);
        else                ovf = (a == {1'b1, {(XW-1){1'b0}}}) && (&b);
        return is_signed_op(op) && ovf;
    endfunction

    // Signs are restored from the original operands; the two corner cases override the iteration result.
    function automatic logic [XW-1:0] divResult(input logic [5:0] op, input logic [XW-1:0] a,
                                                input logic [XW-1:0] b, input logic [XW-1:0] qMag,
                                                input logic [XW-1:0] rMag);
        logic          word;
        logic          negA;
        logic          negB;
        logic [XW-1:0] q;
        logic [XW-1:0] r;
        logic [XW-1:0] res;
        word = is_word_op(op);
        negA = is_signed_op(op) && (word ? a[HW-1] : a[XW-1]);
        negB = is_signed_op(op) && (word ? b[HW-1] : b[XW-1]);
        q = (negA ^ negB) ? -qMag : qMag;
        r = negA ? -rMag : rMag;
        if (divZero(op, b)) begin
            q = '1;
            r = a;
        end else if (divOvf(op, a, b)) begin
            q = a;
            r = '0;
        end
        res = is_rem_op(op) ? r : q;
        if (word) res = {{(XW-HW){res[HW-1]}}, res[HW-1:0]};
        return res;
    endfunction

    assign acceptOp = (state == IDLE) && in_valid && is_muldiv_op(in_op) && !flush;
    assign in_ready = (state == IDLE);
    assign stall    = rst_n && (acceptOp || (state == MUL) || (state == DIV));

`ifdef MULDIV_EARLY_OUT_EN
    assign earlyOut = is_div_op(in_op) && (divZero(in_op, in_b) || divOvf(in_op, in_a, in_b));
`else
    assign earlyOut = 1'b0;
`endif

    // Full-width sign/zero extension makes one modular product serve mul, mulh, mulhsu and mulhu.
    always_comb begin
        mulA    = {{XW{((opReg == OP_MULH) || (opReg == OP_MULHSU)) && aReg[XW-1]}}, aReg};
        mulB    = {{XW{(opReg == OP_MULH) && bReg[XW-1]}}, bReg};
        product = mulA * mulB;
        if (is_word_op(opReg))    mulResult = {{(XW-HW){product[HW-1]}}, product[HW-1:0]};
        else if (opReg == OP_MUL) mulResult = product[XW-1:0];
        else                      mulResult = product[2*XW-1:XW];
    end

    div_unit #(
        .W(XW)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (acceptOp && is_div_op(in_op)),
        .abort     (flush),
        .dividend  (magnitude(in_op, in_a)),
        .divisor   (magnitude(in_op, in_b)),
        .iterCount (is_word_op(in_op) ? ITER_WORD : ITER_FULL),
        .quotient  (divQuo),
        .remainder (divRem),
        .done      (divDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            aReg         <= '0;
            bReg         <= '0;
            opReg        <= '0;
            destReg      <= '0;
            mulCnt       <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_dest_reg <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (acceptOp) begin
                        aReg    <= in_a;
                        bReg    <= in_b;
                        opReg   <= in_op;
                        destReg <= in_dest_reg;
                        mulCnt  <= MUL_LAST;
                        if (earlyOut) begin
                            state        <= DONE;
                            out_valid    <= 1'b1;
                            out_result   <= divResult(in_op, in_a, in_b, '0, '0);
                            out_dest_reg <= in_dest_reg;
                        end else if (is_div_op(in_op)) begin
                            state <= DIV;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (mulCnt == '0) begin
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        out_result   <= mulResult;
                        out_dest_reg <= destReg;
                    end else begin
                        mulCnt <= mulCnt - 1'b1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (divDone) begin
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        out_result   <= divResult(opReg, aReg, bReg, divQuo, divRem);
                        out_dest_reg <= destReg;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
